vga_scanout: RTL and testbench

Display-side reader for the 640x240 pixel frame buffer. It generates 640x480@60 VGA timing from a 25 MHz pixel clock and drives frame-buffer read addresses one pixel ahead, compensating the buffer's one-cycle registered-address read. Each stored row is shown on two consecutive display lines. It emits aligned RGB, HSYNC, VSYNC and data-enable to the DAC/pins, plus a start-of-vblank pulse so writers can sequence frame updates.

---
 rtl/vga_scanout.sv | 150 +++++++++++++++
 tb/tb_vga_scanout.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : 640x480@60 VGA timing and frame-buffer reader for a 640x240
//            buffer, with line doubling and 3-stage aligned outputs.
//            Optional VGA_SCANOUT_TEST_PATTERN_EN adds colour bars on test_en.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 19,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    input  logic [DATA_WIDTH-1:0] fb_q,
    input  logic                  test_en,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  vblank_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_WIDTH-1:0] c_line_step = ADDR_WIDTH'(H_ACTIVE);

    logic [c_hw-1:0]       r_h_cnt;
    logic [c_vw-1:0]       r_v_cnt;
    logic [ADDR_WIDTH-1:0] r_line_base;

    logic w_h_last;
    logic w_v_last;
    logic w_v_act;
    logic w_active;
    logic w_hsync_raw;
    logic w_vsync_raw;

    assign w_h_last    = (r_h_cnt == c_h_last);
    assign w_v_last    = (r_v_cnt == c_v_last);
    assign w_v_act     = (r_v_cnt < c_v_act);
    assign w_active    = (r_h_cnt < c_h_act) && w_v_act;
    assign w_hsync_raw = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vsync_raw = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));

    // Taken straight from the counters so writers see it at the true (0,V_ACTIVE) cycle.
    assign vblank_start = (r_h_cnt == '0) && (r_v_cnt == c_v_act);

    // line_base advances only after odd lines, so each stored row is shown twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_line_base <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
                r_v_cnt     <= '0;
                r_line_base <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + c_vw'(1);
                if (r_v_cnt[0] && w_v_act) begin
                    r_line_base <= r_line_base + c_line_step;
                end
            end
        end else begin
            r_h_cnt <= r_h_cnt + c_hw'(1);
        end
    end

    logic r_act1;
    logic r_act2;
    logic r_hs1;
    logic r_hs2;
    logic r_vs1;
    logic r_vs2;
    logic [DATA_WIDTH-1:0] w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr <= '0;
            r_act1  <= 1'b0;
            r_act2  <= 1'b0;
            r_hs1   <= 1'b1;
            r_hs2   <= 1'b1;
            r_vs1   <= 1'b1;
            r_vs2   <= 1'b1;
            rgb     <= '0;
            de      <= 1'b0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            fb_addr <= w_active ? (r_line_base + ADDR_WIDTH'(r_h_cnt)) : '0;
            r_act1  <= w_active;
            r_hs1   <= w_hsync_raw;
            r_vs1   <= w_vsync_raw;
            r_act2  <= r_act1;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            rgb     <= r_act2 ? w_pix : '0;
            de      <= r_act2;
            hsync   <= r_hs2;
            vsync   <= r_vs2;
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] r_bar1;
    logic [DATA_WIDTH-1:0] r_bar2;

    // Bars are 64 pixels wide; delayed to meet fb_q at the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar1 <= '0;
            r_bar2 <= '0;
        end else begin
            r_bar1 <= DATA_WIDTH'(r_h_cnt >> 6);
            r_bar2 <= r_bar1;
        end
    end

    assign w_pix = test_en ? r_bar2 : fb_q;
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;
    assign w_pix            = fb_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Directed self-checking bench for vga_scanout (reduced vertical
//            geometry: 8 active lines, 15-line frame of 12000 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_en = 1'b0;
    logic [18:0] fb_addr;
    logic [2:0]  fb_q = 3'd0;
    logic [2:0]  rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        vblank_start;

    int checks = 0;
    int errors = 0;
    int m = 0;
    int de_cnt = 0;
    int hs_low = 0;
    int vs_low = 0;
    int vb_cnt = 0;

    vga_scanout #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fb_addr      (fb_addr),
        .fb_q         (fb_q),
        .test_en      (test_en),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .vblank_start (vblank_start)
    );

    always #20 clk = ~clk;

    // Frame buffer holding ram[k] = k mod 8, registered-address read.
    always @(posedge clk) fb_q <= fb_addr[2:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // m counts rising edges since reset release; counter index equals m.
    task automatic step_to(input int target);
        while (m < target) begin
            @(posedge clk);
            m++;
            @(negedge clk);
            if (de) de_cnt++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (vblank_start) vb_cnt++;
        end
    endtask

    task automatic release_reset;
        @(negedge clk);
        rst_n  = 1'b1;
        m      = 0;
        de_cnt = 0;
        hs_low = 0;
        vs_low = 0;
        vb_cnt = 0;
    endtask

    task automatic probe(input int pm, input int e_addr, input int e_de, input int e_hs,
                         input int e_vs, input int e_rgb, input int e_vb);
        step_to(pm);
        check($sformatf("m%0d fb_addr", pm), 32'(fb_addr), e_addr);
        check($sformatf("m%0d de", pm), 32'(de), e_de);
        check($sformatf("m%0d hsync", pm), 32'(hsync), e_hs);
        check($sformatf("m%0d vsync", pm), 32'(vsync), e_vs);
        check($sformatf("m%0d rgb", pm), 32'(rgb), e_rgb);
        check($sformatf("m%0d vblank", pm), 32'(vblank_start), e_vb);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " fb_addr"}, 32'(fb_addr), 0);
        check({tag, " rgb"}, 32'(rgb), 0);
        check({tag, " de"}, 32'(de), 0);
        check({tag, " hsync"}, 32'(hsync), 1);
        check({tag, " vsync"}, 32'(vsync), 1);
        check({tag, " vblank"}, 32'(vblank_start), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");

        release_reset();
        step_to(300);
        check("run de", 32'(de), 1);
        check("run rgb", 32'(rgb), 1);
        step_to(700);
        check("run hsync low", 32'(hsync), 0);
        #5 rst_n = 1'b0;
        #1 check_idle("async reset");

        release_reset();
        //     m      addr  de hs vs rgb vb
        probe(1,      0,    0, 1, 1, 0, 0);
        probe(2,      1,    0, 1, 1, 0, 0);
        probe(3,      2,    1, 1, 1, 0, 0);
        probe(8,      7,    1, 1, 1, 5, 0);
        probe(642,    0,    1, 1, 1, 7, 0);
        probe(643,    0,    0, 1, 1, 0, 0);
        probe(658,    0,    0, 1, 1, 0, 0);
        probe(659,    0,    0, 0, 1, 0, 0);
        probe(754,    0,    0, 0, 1, 0, 0);
        probe(755,    0,    0, 1, 1, 0, 0);
        probe(813,    12,   1, 1, 1, 2, 0);
        probe(1606,   645,  1, 1, 1, 3, 0);
        probe(1608,   647,  1, 1, 1, 5, 0);
        probe(6240,   2559, 1, 1, 1, 5, 0);
        probe(6242,   0,    1, 1, 1, 7, 0);
        probe(6399,   0,    0, 1, 1, 0, 0);
        probe(6400,   0,    0, 1, 1, 0, 1);
        probe(6401,   0,    0, 1, 1, 0, 0);
        probe(6403,   0,    0, 1, 1, 0, 0);
        probe(8002,   0,    0, 1, 1, 0, 0);
        probe(8003,   0,    0, 1, 0, 0, 0);
        probe(9602,   0,    0, 1, 0, 0, 0);
        probe(9603,   0,    0, 1, 1, 0, 0);

        step_to(12000);
        check("frame de cycles", de_cnt, 5120);
        check("frame hsync low cycles", hs_low, 1440);
        check("frame vsync low cycles", vs_low, 1600);
        check("frame vblank pulses", vb_cnt, 1);

        probe(12003,  2,    1, 1, 1, 0, 0);
        probe(12011,  10,   1, 1, 1, 0, 0);

        @(negedge clk);
        rst_n   = 1'b0;
        @(negedge clk);
        test_en = 1'b1;
        release_reset();
        step_to(3);
        check("tp h0 rgb", 32'(rgb), 0);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        step_to(69);
        check("tp h66 rgb", 32'(rgb), 1);
        step_to(131);
        check("tp h128 rgb", 32'(rgb), 2);
        step_to(605);
        check("tp h602 rgb", 32'(rgb), 1);
`else
        step_to(69);
        check("tp h66 rgb", 32'(rgb), 2);
        step_to(131);
        check("tp h128 rgb", 32'(rgb), 0);
        step_to(605);
        check("tp h602 rgb", 32'(rgb), 2);
`endif
        step_to(643);
        check("tp blank rgb", 32'(rgb), 0);
        check("tp blank fb_addr", 32'(fb_addr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
